// File: rtl/ucsbece152a_ssd_scan.sv
// ucsbece152a_ssd_scan
// Time-multiplexed scan controller that shares one 3-bit seven-segment
// decoder across NUM_DIGITS common-anode digits. New digit values arrive
// through a valid/ready handshake. The first load after reset is applied
// directly. Later loads wait in a shadow register and are swapped in only at
// a frame boundary, so a frame never mixes old and new digit values. Each
// digit slot is BLANK_CYCLES of all-dark guard time followed by
// REFRESH_CYCLES with the digit lit.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   load_valid_i   load request
//   load_ready_o   high when load_data_i can be accepted
//   load_data_i    packed digit values, digit k in bits [3k+2:3k]
//   digit_en_i     per-digit enable; a disabled digit keeps its slot but stays dark
//   dec_data_o     value of the scanned digit, to the shared decoder
//   anode_o        active-low one-hot digit select
//   digit_idx_o    index of the current slot
//   frame_start_o  pulse in the first cycle of digit 0's slot
module ucsbece152a_ssd_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [3*NUM_DIGITS-1:0]       load_data_i,
    input  logic [NUM_DIGITS-1:0]         digit_en_i,
    output logic [2:0]                    dec_data_o,
    output logic [NUM_DIGITS-1:0]         anode_o,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_o,
    output logic                          frame_start_o
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    // With no blanking guard, every slot opens directly in SHOW.
    localparam state_t SLOT_FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3*NUM_DIGITS-1:0] active_q;
    logic [3*NUM_DIGITS-1:0] pending_q;
    logic                    pending_valid_q;
    logic                    transfer;
    logic                    boundary;

    // Ready depends only on registered state, so it has no path from valid.
    assign load_ready_o = ~pending_valid_q;
    assign transfer     = load_valid_i && ~pending_valid_q;

    // The edge that ends the last digit's lit time and wraps the scan to digit 0.
    assign boundary = (state_q == SHOW) && (cnt_q == REFRESH_LAST) && (idx_q == IDX_LAST);

    // Scan state, slot index and dwell counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE waits for the first load, then each slot runs
    // BLANK (guard) followed by SHOW (lit), advancing the index after SHOW.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SLOT_FIRST;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == REFRESH_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = SLOT_FIRST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit data. The first load goes straight to the displayed set; later
    // loads park in the shadow register until the frame wraps. A transfer
    // cannot coincide with a pending swap because ready is low while the
    // shadow is full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
        end else if (transfer) begin
            if (state_q == IDLE) begin
                active_q <= load_data_i;
            end else begin
                pending_q       <= load_data_i;
                pending_valid_q <= 1'b1;
            end
        end else if (boundary && pending_valid_q) begin
            active_q        <= pending_q;
            pending_valid_q <= 1'b0;
        end
    end

    // Output decode. The decoder value is held through BLANK so it settles
    // before the anode turns on; the anode only lights in SHOW and only for
    // an enabled digit.
    always_comb begin
        anode_o    = '1;
        dec_data_o = '0;
        if (state_q != IDLE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    dec_data_o = active_q[3*k +: 3];
                    if (state_q == SHOW) begin
                        anode_o[k] = ~digit_en_i[k];
                    end
                end
            end
        end
    end

    assign digit_idx_o   = idx_q;
    assign frame_start_o = (state_q == SLOT_FIRST) && (idx_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_ucsbece152a_ssd_scan.sv
// tb_ucsbece152a_ssd_scan
// Directed testbench for the scan controller with NUM_DIGITS=4,
// REFRESH_CYCLES=4, BLANK_CYCLES=1 (20-cycle frames). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_ucsbece152a_ssd_scan;

    localparam int ND    = 4;
    localparam int FRAME = 20;
    localparam int SLOT  = 5;

    logic        clk;
    logic        rstN;
    logic        loadValid;
    logic        loadReady;
    logic [11:0] loadData;
    logic [3:0]  digitEn;
    logic [2:0]  decData;
    logic [3:0]  anode;
    logic [1:0]  digitIdx;
    logic        frameStart;

    int          assertCount = 0;
    int          failCount   = 0;
    int          xferCount   = 0;
    logic [11:0] xferData [$];
    bit          feedActive  = 0;
    int          feedBase    = 0;

    ucsbece152a_ssd_scan #(
        .NUM_DIGITS     (ND),
        .REFRESH_CYCLES (4),
        .BLANK_CYCLES   (1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .load_valid_i  (loadValid),
        .load_ready_o  (loadReady),
        .load_data_i   (loadData),
        .digit_en_i    (digitEn),
        .dec_data_o    (decData),
        .anode_o       (anode),
        .digit_idx_o   (digitIdx),
        .frame_start_o (frameStart)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records every accepted transfer so loss or duplication is visible.
    always @(posedge clk) begin
        if (rstN && loadValid && loadReady) begin
            xferCount = xferCount + 1;
            xferData.push_back(loadData);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic valid, input logic [11:0] data, input logic [3:0] en);
        loadValid = valid;
        loadData  = data;
        digitEn   = en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_anode"}, 32'(anode), 32'hF);
        checkOutput({tag, "_dec"}, 32'(decData), 32'h0);
        checkOutput({tag, "_ready"}, 32'(loadReady), 32'h1);
        checkOutput({tag, "_fs"}, 32'(frameStart), 32'h0);
        checkOutput({tag, "_idx"}, 32'(digitIdx), 32'h0);
    endtask

    // Walks one whole frame from its start cycle, comparing against the
    // expected slot pattern. Optionally issues a one-cycle load at offset
    // loadAt, and services the continuous-valid feed when it is enabled.
    task automatic checkFrame(input string tag, input logic [11:0] digits, input logic [3:0] en,
                              input int loadAt, input logic [11:0] newData);
        for (int t = 0; t < FRAME; t++) begin
            int         slot;
            int         phase;
            logic [3:0] expAnode;
            logic [2:0] expDec;
            slot     = t / SLOT;
            phase    = t % SLOT;
            expAnode = 4'hF;
            if (phase != 0) expAnode[slot] = ~en[slot];
            expDec = digits[slot*3 +: 3];
            checkOutput($sformatf("%s_anode_t%0d", tag, t), 32'(anode), 32'(expAnode));
            checkOutput($sformatf("%s_dec_t%0d", tag, t), 32'(decData), 32'(expDec));
            checkOutput($sformatf("%s_fs_t%0d", tag, t), 32'(frameStart), (t == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("%s_idx_t%0d", tag, t), 32'(digitIdx), 32'(slot));
            if (loadAt >= 0 && t == loadAt) begin
                applyStimulus(1'b1, newData, en);
            end
            if (loadAt >= 0 && t == loadAt + 1) begin
                checkOutput($sformatf("%s_ready_after_load", tag), 32'(loadReady), 32'h0);
                applyStimulus(1'b0, newData, en);
            end
            if (feedActive) begin
                if (xferCount - feedBase == 1) begin
                    applyStimulus(1'b1, 12'o6666, en);
                end else if (xferCount - feedBase >= 2) begin
                    applyStimulus(1'b0, 12'o6666, en);
                    feedActive = 0;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 12'o0, 4'hF);

        // Reset held with random inputs, then idle with no load.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 4'($urandom));
            @(negedge clk);
            checkIdle($sformatf("rst_hold%0d", i));
        end
        applyStimulus(1'b0, 12'o0, 4'hF);
        rstN = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkIdle($sformatf("idle%0d", i));
        end

        // First load goes straight to the display.
        applyStimulus(1'b1, 12'o7531, 4'hF);
        @(negedge clk);
        applyStimulus(1'b0, 12'o7531, 4'hF);
        checkOutput("first_ready", 32'(loadReady), 32'h1);
        checkFrame("f1", 12'o7531, 4'hF, -1, 12'o0);

        // Load during digit 1's slot; old digits persist until the wrap.
        checkFrame("f2", 12'o7531, 4'hF, SLOT, 12'o2222);
        checkOutput("ready_after_boundary", 32'(loadReady), 32'h1);
        checkFrame("f3", 12'o2222, 4'hF, -1, 12'o0);

        // Continuous valid: one transfer per frame boundary.
        feedBase   = xferCount;
        feedActive = 1;
        applyStimulus(1'b1, 12'o1111, 4'hF);
        checkFrame("f4", 12'o2222, 4'hF, -1, 12'o0);
        checkOutput("bp_xfers_a", 32'(xferCount - feedBase), 32'd1);
        checkOutput("bp_ready_a", 32'(loadReady), 32'h1);
        checkFrame("f5", 12'o1111, 4'hF, -1, 12'o0);
        checkOutput("bp_xfers_b", 32'(xferCount - feedBase), 32'd2);
        checkOutput("bp_ready_b", 32'(loadReady), 32'h1);
        checkOutput("bp_valid_dropped", 32'(loadValid), 32'h0);
        checkFrame("f6", 12'o6666, 4'hF, -1, 12'o0);
        checkOutput("bp_xfers_c", 32'(xferCount - feedBase), 32'd2);
        if (xferData.size() >= feedBase + 2) begin
            checkOutput("bp_data0", 32'(xferData[feedBase]), 32'(12'o1111));
            checkOutput("bp_data1", 32'(xferData[feedBase + 1]), 32'(12'o6666));
        end else begin
            checkOutput("bp_data_count", 32'(xferData.size()), 32'(feedBase + 2));
        end

        // Digit 2 disabled: its slot stays dark, frame length unchanged.
        applyStimulus(1'b0, 12'o0, 4'b1011);
        checkFrame("f7", 12'o6666, 4'b1011, -1, 12'o0);
        checkOutput("dis_period_fs", 32'(frameStart), 32'h1);

        // Reset mid-SHOW of digit 2 with the shadow register full.
        applyStimulus(1'b1, 12'o3333, 4'hF);
        @(negedge clk);
        applyStimulus(1'b0, 12'o3333, 4'hF);
        checkOutput("mid_pending_ready", 32'(loadReady), 32'h0);
        repeat (11) @(negedge clk);
        checkOutput("mid_anode_before_rst", 32'(anode), 32'hB);
        #2 rstN = 1'b0;
        #1 checkIdle("mid_rst_now");
        @(negedge clk);
        checkIdle("mid_rst_held");
        rstN = 1'b1;
        applyStimulus(1'b1, 12'o0004, 4'hF);
        @(negedge clk);
        applyStimulus(1'b0, 12'o0004, 4'hF);
        checkFrame("f8", 12'o0004, 4'hF, -1, 12'o0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
